// File: rtl/imem_fetch_ctrl.sv
// Instruction fetch controller: drives a combinational instruction memory from an
// internal PC and hands registered instructions to decode over a valid/ready pair.
module imem_fetch_ctrl #(
   parameter int                      ADDRESS_WIDTH     = 8,
   parameter int                      INSTRUCTION_WIDTH = 16,
   parameter int                      PC_INCREMENT_VAL  = 2,
   parameter int                      RESET_PC          = 0,
   parameter int                      OPCODE_WIDTH      = 4,
   parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE       = 4'hF
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         start,
   input  logic                         redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0]     redirect_addr,
   output logic [ADDRESS_WIDTH-1:0]     imem_addr,
   input  logic [INSTRUCTION_WIDTH-1:0] imem_instr,
   output logic [INSTRUCTION_WIDTH-1:0] instr,
   output logic [ADDRESS_WIDTH-1:0]     instr_pc,
   output logic                         instr_valid,
   input  logic                         instr_ready,
   output logic                         halted,
   output logic [15:0]                  instr_count
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, HALTED} state_t;

   localparam logic [ADDRESS_WIDTH-1:0] PC_STEP = ADDRESS_WIDTH'(PC_INCREMENT_VAL);
   localparam logic [ADDRESS_WIDTH-1:0] PC_INIT = ADDRESS_WIDTH'(RESET_PC);

   state_t                   state;
   logic [ADDRESS_WIDTH-1:0] pc;
   logic                     transfer;
   logic                     capture;
   logic                     is_halt;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign imem_addr = pc;
   assign transfer  = instr_valid & instr_ready;
   assign capture   = ~instr_valid | instr_ready;
   assign is_halt   = (imem_instr[INSTRUCTION_WIDTH-1 -: OPCODE_WIDTH] == HALT_OPCODE);

   // Redirect outranks both capture and acceptance: the held instruction is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         pc          <= PC_INIT;
         instr       <= '0;
         instr_pc    <= '0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         instr_count <= 16'd0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  pc    <= PC_INIT;
                  state <= RUN;
               end
            end
            RUN: begin
               if (redirect_valid) begin
                  instr_valid <= 1'b0;
                  pc          <= redirect_addr;
               end else if (capture) begin
                  if (transfer)
                     instr_count <= sat_inc(instr_count);
                  instr       <= imem_instr;
                  instr_pc    <= pc;
                  instr_valid <= 1'b1;
                  // A HALT leaves pc pointing at itself so fetching stops there.
                  if (is_halt)
                     state <= DRAIN;
                  else
                     pc <= pc + PC_STEP;
               end
            end
            DRAIN: begin
               if (redirect_valid) begin
                  instr_valid <= 1'b0;
                  pc          <= redirect_addr;
                  state       <= RUN;
               end else if (transfer) begin
                  instr_count <= sat_inc(instr_count);
                  instr_valid <= 1'b0;
                  halted      <= 1'b1;
                  state       <= HALTED;
               end
            end
            HALTED: begin
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: cycle table plus hand sequences, with a transfer
// scoreboard that pairs every expected acceptance with the one the DUT makes.
module tb_imem_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [7:0]  redirect_addr = 8'h00;
   logic        instr_ready = 1'b0;
   logic [7:0]  imem_addr;
   logic [15:0] imem_instr;
   logic [15:0] instr;
   logic [7:0]  instr_pc;
   logic        instr_valid;
   logic        halted;
   logic [15:0] instr_count;

   logic [15:0] mem [0:255];
   int          n_cmp = 0;
   int          n_bad = 0;

   typedef struct {
      logic        st;
      logic        rv;
      logic [7:0]  ra;
      logic        rdy;
      logic        ev;
      logic [15:0] ei;
      logic [7:0]  epc;
      logic [7:0]  ea;
      logic [15:0] ec;
      logic        eh;
   } vec_t;

   typedef struct {
      logic [7:0]  pc;
      logic [15:0] ins;
   } xfer_t;

   localparam int NV = 21;
   vec_t  tbl [NV];
   xfer_t sbq [$];
   xfer_t popped;
   xfer_t pushed;

   imem_fetch_ctrl #(
      .ADDRESS_WIDTH(8), .INSTRUCTION_WIDTH(16), .PC_INCREMENT_VAL(2),
      .RESET_PC(0), .OPCODE_WIDTH(4), .HALT_OPCODE(4'hF)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .redirect_valid(redirect_valid), .redirect_addr(redirect_addr),
      .imem_addr(imem_addr), .imem_instr(imem_instr),
      .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
      .instr_ready(instr_ready), .halted(halted), .instr_count(instr_count)
   );

   always #5 clk = ~clk;
   assign imem_instr = mem[imem_addr];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic st, input logic rv, input logic [7:0] ra,
                               input logic rdy, input logic ev, input logic [15:0] ei,
                               input logic [7:0] epc, input logic [7:0] ea,
                               input logic [15:0] ec, input logic eh);
      vec_t v;
      v.st = st; v.rv = rv; v.ra = ra; v.rdy = rdy; v.ev = ev;
      v.ei = ei; v.epc = epc; v.ea = ea; v.ec = ec; v.eh = eh;
      return v;
   endfunction

   task automatic expect_xfer(input logic [7:0] pc, input logic [15:0] ins);
      pushed.pc  = pc;
      pushed.ins = ins;
      sbq.push_back(pushed);
   endtask

   task automatic chk_out(input string tag, input logic ev, input logic [15:0] ei,
                          input logic [7:0] epc, input logic [7:0] ea,
                          input logic [15:0] ec, input logic eh);
      chk({tag, "_valid"}, 32'(instr_valid), 32'(ev));
      chk({tag, "_imem_addr"}, 32'(imem_addr), 32'(ea));
      chk({tag, "_count"}, 32'(instr_count), 32'(ec));
      chk({tag, "_halted"}, 32'(halted), 32'(eh));
      if (ev) begin
         chk({tag, "_instr"}, 32'(instr), 32'(ei));
         chk({tag, "_instr_pc"}, 32'(instr_pc), 32'(epc));
      end
   endtask

   // Scoreboard side: every acceptance the DUT makes must match the next expected one.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
         if (sbq.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_unexpected: got transfer pc 0x%0h required none", instr_pc);
         end else begin
            popped = sbq.pop_front();
            chk("sb_pc", 32'(instr_pc), 32'(popped.pc));
            chk("sb_instr", 32'(instr), 32'(popped.ins));
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish required finish");
      $fatal(1);
   end

   initial begin
      for (int a = 0; a < 256; a++)
         mem[a] = {4'h1, 8'(a), 4'h5};
      mem[8'h00] = 16'h1111;
      mem[8'h02] = 16'h2222;
      mem[8'h04] = 16'h3333;
      mem[8'h06] = 16'hF000;
      mem[8'h40] = 16'h4040;
      mem[8'h42] = 16'h4242;
      mem[8'hFE] = 16'h1EFE;
      mem[8'h41] = 16'h2A41;

      //            st    rv    ra     rdy   ev    ei        epc    ea     ec      eh
      tbl[0]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0, 1'b0);
      tbl[1]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h00, 16'd0, 1'b0);
      tbl[2]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h1111, 8'h00, 8'h02, 16'd0, 1'b0);
      tbl[3]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h2222, 8'h02, 8'h04, 16'd1, 1'b0);
      tbl[4]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h3333, 8'h04, 8'h06, 16'd2, 1'b0);
      tbl[5]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h3333, 8'h04, 8'h06, 16'd2, 1'b0);
      tbl[6]  = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'h3333, 8'h04, 8'h06, 16'd2, 1'b0);
      tbl[7]  = mk(1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 16'h3333, 8'h04, 8'h06, 16'd2, 1'b0);
      tbl[8]  = mk(1'b0, 1'b1, 8'h40, 1'b1, 1'b1, 16'hF000, 8'h06, 8'h06, 16'd3, 1'b0);
      tbl[9]  = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h40, 16'd3, 1'b0);
      tbl[10] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h4040, 8'h40, 8'h42, 16'd3, 1'b0);
      tbl[11] = mk(1'b0, 1'b1, 8'hFE, 1'b1, 1'b1, 16'h4242, 8'h42, 8'h44, 16'd4, 1'b0);
      tbl[12] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 8'hFE, 16'd4, 1'b0);
      tbl[13] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h1EFE, 8'hFE, 8'h00, 16'd4, 1'b0);
      tbl[14] = mk(1'b0, 1'b1, 8'h06, 1'b1, 1'b1, 16'h1111, 8'h00, 8'h02, 16'd5, 1'b0);
      tbl[15] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h06, 16'd5, 1'b0);
      tbl[16] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'hF000, 8'h06, 8'h06, 16'd5, 1'b0);
      tbl[17] = mk(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 16'hF000, 8'h06, 8'h06, 16'd5, 1'b0);
      tbl[18] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'hF000, 8'h06, 8'h06, 16'd5, 1'b0);
      tbl[19] = mk(1'b1, 1'b1, 8'h40, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h06, 16'd6, 1'b1);
      tbl[20] = mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 8'h00, 8'h06, 16'd6, 1'b1);

      // Reset state while rst_n is held low
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk_out("reset", 1'b0, 16'h0, 8'h0, 8'h00, 16'd0, 1'b0);
      chk("reset_instr", 32'(instr), 32'h0);
      chk("reset_instr_pc", 32'(instr_pc), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Table: inputs drive the coming edge, expectations reflect the state already reached
      for (int i = 0; i < NV; i++) begin
         @(posedge clk); #1;
         start          = tbl[i].st;
         redirect_valid = tbl[i].rv;
         redirect_addr  = tbl[i].ra;
         instr_ready    = tbl[i].rdy;
         if (tbl[i].ev && tbl[i].rdy && !tbl[i].rv)
            expect_xfer(tbl[i].epc, tbl[i].ei);
         @(negedge clk);
         chk_out($sformatf("row%0d", i), tbl[i].ev, tbl[i].ei, tbl[i].epc,
                 tbl[i].ea, tbl[i].ec, tbl[i].eh);
      end

      // Asynchronous reset out of HALTED, checked before the next edge
      @(posedge clk); #1;
      start = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk_out("arst_halted", 1'b0, 16'h0, 8'h0, 8'h00, 16'd0, 1'b0);

      // Restart, reach a stall, then reset mid-stall
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk_out("lat1", 1'b0, 16'h0, 8'h0, 8'h00, 16'd0, 1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_out("lat2", 1'b1, 16'h1111, 8'h00, 8'h02, 16'd0, 1'b0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk_out("arst_stall", 1'b0, 16'h0, 8'h0, 8'h00, 16'd0, 1'b0);
      chk("arst_stall_instr", 32'(instr), 32'h0);
      chk("arst_stall_instr_pc", 32'(instr_pc), 32'h0);

      // Without start the block stays idle at RESET_PC
      @(posedge clk); #1;
      rst_n = 1'b1; instr_ready = 1'b1;
      repeat (3) begin
         @(posedge clk); #1;
         @(negedge clk);
         chk_out("idle_wait", 1'b0, 16'h0, 8'h0, 8'h00, 16'd0, 1'b0);
      end

      // Odd redirect target is used as-is
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      redirect_valid = 1'b1; redirect_addr = 8'h41;
      @(negedge clk);
      chk_out("odd_pre", 1'b1, 16'h1111, 8'h00, 8'h02, 16'd0, 1'b0);
      @(posedge clk); #1;
      redirect_valid = 1'b0;
      @(negedge clk);
      chk_out("odd_drop", 1'b0, 16'h0, 8'h0, 8'h41, 16'd0, 1'b0);
      @(posedge clk); #1;
      expect_xfer(8'h41, 16'h2A41);
      @(negedge clk);
      chk_out("odd_fetch", 1'b1, 16'h2A41, 8'h41, 8'h43, 16'd0, 1'b0);
      @(posedge clk); #1;
      instr_ready = 1'b0;
      @(negedge clk);
      chk_out("odd_next", 1'b1, 16'h1435, 8'h43, 8'h45, 16'd1, 1'b0);

      @(posedge clk); #1;
      chk("sb_leftover", 32'(sbq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/imem_fetch_ctrl.md
IMEM_FETCH_CTRL -- requirements
Module: imem_fetch_ctrl

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 8, meaning byte address width of instruction memory and PC.
REQ-002 SHALL have parameter INSTRUCTION_WIDTH, default 16, meaning fetched instruction width.
REQ-003 SHALL have parameter PC_INCREMENT_VAL, default 2, meaning sequential PC step in bytes.
REQ-004 SHALL have parameter RESET_PC, default 0, meaning first fetch address after start.
REQ-005 SHALL have parameter OPCODE_WIDTH, default 4, meaning width of the opcode field at instruction MSBs.
REQ-006 SHALL have parameter HALT_OPCODE, default 4'hF, meaning opcode that stops fetching.
REQ-007 SHALL have port clk  in  1  the single clock; all state on its rising edge.
REQ-008 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-009 SHALL have port start  in  1  one-cycle pulse; begin fetching from RESET_PC.
REQ-010 SHALL have port redirect_valid  in  1  branch/jump taken this cycle.
REQ-011 SHALL have port redirect_addr  in  ADDRESS_WIDTH  branch/jump target.
REQ-012 SHALL have port imem_addr  out  ADDRESS_WIDTH  address to combinational instruction memory.
REQ-013 SHALL have port imem_instr  in  INSTRUCTION_WIDTH  memory read data, valid same cycle as imem_addr.
REQ-014 SHALL have port instr  out  INSTRUCTION_WIDTH  registered instruction to decode.
REQ-015 SHALL have port instr_pc  out  ADDRESS_WIDTH  address instr was fetched from.
REQ-016 SHALL have port instr_valid  out  1  instr/instr_pc hold a valid instruction.
REQ-017 SHALL have port instr_ready  in  1  decode accepts instr this cycle.
REQ-018 SHALL have port halted  out  1  HALT instruction accepted; fetching stopped.
REQ-019 SHALL have port instr_count  out  16  number of accepted instructions, saturating at 16'hFFFF.

Function
REQ-020 SHALL implement states IDLE, RUN, DRAIN, HALTED.
REQ-021 SHALL drive imem_addr = pc (internal register) continuously in all states.
REQ-022 IDLE: start -> pc <= RESET_PC, RUN; redirect_valid ignored.
REQ-023 RUN: capture when !instr_valid or (instr_valid and instr_ready): instr <= imem_instr, instr_pc <= pc, instr_valid <= 1, pc <= pc + PC_INCREMENT_VAL.
REQ-024 RUN: instr_valid and !instr_ready -> instr, instr_pc, pc all held (stall); no capture.
REQ-025 Acceptance (transfer) SHALL be instr_valid and instr_ready in the same cycle; each transfer increments instr_count by 1 unless saturated.
REQ-026 Latency: first instr_valid SHALL assert exactly 2 cycles after the start pulse cycle (1 cycle to load pc, 1 to capture).
REQ-027 PC arithmetic SHALL be modulo 2**ADDRESS_WIDTH; wrap from top of address space to low addresses is silent.
REQ-028 redirect_valid in RUN or DRAIN SHALL take priority over capture: next cycle instr_valid = 0, pc = redirect_addr, state = RUN; held instruction is dropped (not counted even if instr_ready was high).
REQ-029 Capture of an instruction whose top OPCODE_WIDTH bits equal HALT_OPCODE SHALL move RUN -> DRAIN; pc not incremented.
REQ-030 DRAIN: no capture; on transfer of the HALT instruction -> HALTED, instr_valid <= 0, halted <= 1.
REQ-031 HALTED: start, redirect_valid, instr_ready ignored; exit only by reset.
REQ-032 start in RUN or DRAIN SHALL be ignored.
REQ-033 Odd redirect_addr SHALL be accepted unmodified (no alignment).

Reset
REQ-034 rst_n low SHALL immediately force state IDLE, pc = RESET_PC, instr = 0, instr_pc = 0, instr_valid = 0, halted = 0, instr_count = 0, mid-operation included.
REQ-035 First fetch capture after rst_n deassertion SHALL require a start pulse.

Verification
REQ-036 Reset, start, instr_ready = 1, memory words 0x1111, 0x2222, 0x3333 at 0, 2, 4 -> instr_valid at cycle +2, instr_pc 0, 2, 4 consecutive cycles, instr_count 3.
REQ-037 instr_ready = 0 for 3 cycles while instr_valid -> instr/instr_pc/imem_addr stable, instr_count unchanged; resume with no skipped or duplicated instruction.
REQ-038 redirect_valid = 1, redirect_addr = 0x40 with instr_valid and instr_ready high -> next cycle instr_valid = 0, imem_addr = 0x40, count unchanged; following cycle instr_pc = 0x40.
REQ-039 Memory word 0xF000 at 0x06 -> DRAIN, imem_addr stays 0x06; after acceptance halted = 1, instr_valid = 0; later start ignored.
REQ-040 ADDRESS_WIDTH = 8, redirect to 0xFE -> next instr_pc sequence 0xFE, 0x00.
REQ-041 rst_n asserted asynchronously mid-stall -> all outputs at reset values before next clock edge; IDLE until start.
